// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared encodings for the load/store bus controller.
// Size codes, FSM states, error codes and the alignment check.
package mem_bus_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // A double access on a 32-bit datapath has no legal
    // alignment, so it is folded into the misaligned trap.
    function automatic logic misaligned(
        input logic [1:0] sz,
        input logic [2:0] a,
        input int         xlen
    );
        logic bad;
        bad = 1'b0;
        case (sz)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = a[0];
            SZ_W:    bad = |a[1:0];
            default: bad = (xlen != 64) || (|a);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if: pipeline request/response and external bus signals.
// master = pipeline + memory side, slave = the controller.
interface mem_bus_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              stall;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;
    logic [1:0]        resp_err_code;
    logic              mreq;
    logic              write;
    logic [1:0]        size;
    logic [ADDR_W-1:0] dad;
    logic [XLEN-1:0]   ddt_out;
    logic              ddt_oe;
    logic [XLEN-1:0]   ddt_in;
    logic              ackd_n;

    modport master (
        output req_valid, req_write, req_size, req_signed,
        output req_addr, req_wdata, ddt_in, ackd_n,
        input  stall, resp_valid, resp_rdata, resp_err,
        input  resp_err_code, mreq, write, size, dad,
        input  ddt_out, ddt_oe
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed,
        input  req_addr, req_wdata, ddt_in, ackd_n,
        output stall, resp_valid, resp_rdata, resp_err,
        output resp_err_code, mreq, write, size, dad,
        output ddt_out, ddt_oe
    );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian byte-lane placement (combinational).
// i_load=0 replicates store data; i_load=1 extracts and extends.
module mem_lane_align
    import mem_bus_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                      i_load,
    input  logic [1:0]                i_size,
    input  logic [$clog2(XLEN/8)-1:0] i_lane,
    input  logic                      i_signed,
    input  logic [XLEN-1:0]           i_data,
    output logic [XLEN-1:0]           o_data
);
    localparam logic [XLEN-1:0] M_B = XLEN'(8'hFF);
    localparam logic [XLEN-1:0] M_H = XLEN'(16'hFFFF);
    localparam logic [XLEN-1:0] M_W = XLEN'(32'hFFFF_FFFF);

    logic [XLEN-1:0] w_shift;
    logic [XLEN-1:0] w_mask;
    logic [XLEN-1:0] w_rep;
    logic [XLEN-1:0] w_ext;
    logic            w_sbit;

    assign w_shift = i_data >> {i_lane, 3'b000};

    always_comb begin
        w_rep  = i_data;
        w_mask = '1;
        w_sbit = 1'b0;
        case (i_size)
            SZ_B: begin
                w_rep  = {(XLEN/8){i_data[7:0]}};
                w_mask = M_B;
                w_sbit = w_shift[7];
            end
            SZ_H: begin
                w_rep  = {(XLEN/16){i_data[15:0]}};
                w_mask = M_H;
                w_sbit = w_shift[15];
            end
            SZ_W: begin
                w_rep  = {(XLEN/32){i_data[31:0]}};
                w_mask = M_W;
                w_sbit = w_shift[31];
            end
            default: ;
        endcase
        // Bits above the datum are filled with the sign bit
        // or zero; a full-width access has an all-ones mask.
        w_ext = (w_shift & w_mask)
              | ((i_signed && w_sbit) ? ~w_mask : '0);
        o_data = i_load ? w_ext : w_rep;
    end
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: load/store bus controller with wait states and traps.
// Ports: clk, rst (sync, active high), bus (mem_bus_ctrl_if.slave).
// Optional: MEM_BUS_TIMEOUT_EN adds a BUSY timeout (code 10).
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic           clk,
    input logic           rst,
    mem_bus_ctrl_if.slave bus
);
    localparam int LANE_W = $clog2(XLEN/8);

    if (!(XLEN == 32 || XLEN == 64) || TIMEOUT_CYCLES < 1)
    begin : g_bad_param
        $error("mem_bus_ctrl: illegal XLEN or TIMEOUT_CYCLES");
    end

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_write;
    logic              r_signed;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_rdata;
    logic              r_err;
    logic [1:0]        r_code;
    logic              w_misalign;
    logic              w_ack;
    logic              w_expire;
    logic [XLEN-1:0]   w_st_lane;
    logic [XLEN-1:0]   w_ld_ext;

    assign w_misalign = misaligned(bus.req_size,
                                   bus.req_addr[2:0], XLEN);
    assign w_ack = (r_state == ST_BUSY) && !bus.ackd_n;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    // Held at zero outside BUSY, so it restarts on each entry.
    always_ff @(posedge clk) begin
        if (rst || r_state != ST_BUSY) r_cnt <= '0;
        else                           r_cnt <= r_cnt + 1'b1;
    end

    assign w_expire = (r_state == ST_BUSY)
                   && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_expire = 1'b0;
`endif

    mem_lane_align #(.XLEN(XLEN)) u_wr_align (
        .i_load   (1'b0),
        .i_size   (bus.req_size),
        .i_lane   (bus.req_addr[LANE_W-1:0]),
        .i_signed (1'b0),
        .i_data   (bus.req_wdata),
        .o_data   (w_st_lane)
    );

    mem_lane_align #(.XLEN(XLEN)) u_rd_align (
        .i_load   (1'b1),
        .i_size   (r_size),
        .i_lane   (r_addr[LANE_W-1:0]),
        .i_signed (r_signed),
        .i_data   (bus.ddt_in),
        .o_data   (w_ld_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.req_valid)
                    w_next = w_misalign ? ST_RESP : ST_BUSY;
            end
            // An acknowledge coinciding with expiry still
            // completes normally; the datapath checks w_ack first.
            ST_BUSY: if (w_ack || w_expire) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_size   <= '0;
            r_write  <= 1'b0;
            r_signed <= 1'b0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_code   <= ERR_NONE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_rdata <= '0;
                        if (w_misalign) begin
                            r_err  <= 1'b1;
                            r_code <= ERR_MISALIGN;
                        end else begin
                            r_err    <= 1'b0;
                            r_code   <= ERR_NONE;
                            r_addr   <= bus.req_addr;
                            r_size   <= bus.req_size;
                            r_write  <= bus.req_write;
                            r_signed <= bus.req_signed;
                            r_wdata  <= w_st_lane;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_ack) begin
                        if (!r_write) r_rdata <= w_ld_ext;
                    end else if (w_expire) begin
                        r_err  <= 1'b1;
                        r_code <= ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stall = bus.req_valid && (r_state != ST_RESP);
    assign bus.mreq  = (r_state == ST_BUSY);
    assign bus.write  = bus.mreq && r_write;
    assign bus.ddt_oe = bus.mreq && r_write;
    assign bus.size    = r_size;
    assign bus.dad     = r_addr;
    assign bus.ddt_out = r_wdata;
    assign bus.resp_valid    = (r_state == ST_RESP);
    assign bus.resp_rdata    = r_rdata;
    assign bus.resp_err      = r_err;
    assign bus.resp_err_code = r_code;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed vector bench for mem_bus_ctrl (XLEN=32).
// Timeout sequence only runs when MEM_BUS_TIMEOUT_EN is defined.
module tb_mem_bus_ctrl;
    import mem_bus_pkg::*;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;
    localparam int NV     = 14;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] din;
        int          waits;
        logic        err;
        logic [1:0]  code;
        logic [31:0] rdata;
        logic [31:0] dout;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    mem_bus_ctrl_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

    mem_bus_ctrl #(
        .XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic set_req(input vec_t v);
        bus.req_valid  = 1'b1;
        bus.req_write  = v.wr;
        bus.req_size   = v.sz;
        bus.req_signed = v.sgn;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        bus.ddt_in     = v.din;
        bus.ackd_n     = 1'b1;
    endtask

    // Entered #1 after a rising edge with the DUT idle.
    task automatic do_access(input int idx, input vec_t v);
        int  cyc, nbusy, nstall, lat;
        bit  got;
        string t;
        t = $sformatf("v%0d", idx);
        cyc = 0; nbusy = 0; got = 0;
        lat = v.err ? 1 : v.waits + 2;
        set_req(v);
        #1;
        nstall = bus.stall ? 1 : 0;
        chk({t, "_mreq0"}, bus.mreq, 1'b0);
        while (!got && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.mreq) begin
                if (nbusy == 0) begin
                    chk({t, "_dad"}, bus.dad, v.addr);
                    chk({t, "_size"}, bus.size, v.sz);
                    chk({t, "_write"}, bus.write, v.wr);
                    chk({t, "_oe"}, bus.ddt_oe, v.wr);
                    if (v.wr)
                        chk({t, "_ddt_out"}, bus.ddt_out, v.dout);
                end
                bus.ackd_n = (nbusy == v.waits) ? 1'b0 : 1'b1;
                nbusy++;
            end else begin
                bus.ackd_n = 1'b1;
            end
            if (bus.resp_valid) begin
                got = 1;
                chk({t, "_lat"}, cyc, lat);
                chk({t, "_err"}, bus.resp_err, v.err);
                chk({t, "_code"}, bus.resp_err_code, v.code);
                chk({t, "_rdata"}, bus.resp_rdata, v.rdata);
                chk({t, "_stall_resp"}, bus.stall, 1'b0);
                chk({t, "_mreq_resp"}, bus.mreq, 1'b0);
            end else if (bus.stall) begin
                nstall++;
            end
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: no resp_valid in 40 cycles", t);
        end
        chk({t, "_nbusy"}, nbusy, v.err ? 0 : v.waits + 1);
        chk({t, "_nstall"}, nstall, lat);
        bus.req_valid = 1'b0;
        bus.ackd_n    = 1'b1;
        @(posedge clk); #1;
        chk({t, "_pulse"}, bus.resp_valid, 1'b0);
        chk({t, "_idle_mreq"}, bus.mreq, 1'b0);
    endtask

    initial begin
        // wr sz sgn addr wdata din waits err code rdata dout
        vecs[0]  = '{0, SZ_W, 0, 32'h100, 0, 32'hDEADBEEF,
                     0, 0, ERR_NONE, 32'hDEADBEEF, 0};
        vecs[1]  = '{0, SZ_B, 1, 32'h103, 0, 32'h80123456,
                     0, 0, ERR_NONE, 32'hFFFFFF80, 0};
        vecs[2]  = '{0, SZ_B, 0, 32'h103, 0, 32'h80123456,
                     0, 0, ERR_NONE, 32'h00000080, 0};
        vecs[3]  = '{1, SZ_H, 0, 32'h202, 32'h0000ABCD, 0,
                     3, 0, ERR_NONE, 32'h0, 32'hABCDABCD};
        vecs[4]  = '{0, SZ_W, 0, 32'h101, 0, 32'h12345678,
                     0, 1, ERR_MISALIGN, 32'h0, 0};
        vecs[5]  = '{0, SZ_H, 1, 32'h102, 0, 32'h80017FFF,
                     1, 0, ERR_NONE, 32'hFFFF8001, 0};
        vecs[6]  = '{0, SZ_H, 0, 32'h100, 0, 32'h1234F00D,
                     2, 0, ERR_NONE, 32'h0000F00D, 0};
        vecs[7]  = '{1, SZ_B, 0, 32'h001, 32'hFFFFFF5A, 0,
                     2, 0, ERR_NONE, 32'h0, 32'h5A5A5A5A};
        vecs[8]  = '{1, SZ_W, 0, 32'h004, 32'h12345678, 0,
                     0, 0, ERR_NONE, 32'h0, 32'h12345678};
        vecs[9]  = '{0, SZ_D, 0, 32'h000, 0, 32'h11111111,
                     0, 1, ERR_MISALIGN, 32'h0, 0};
        vecs[10] = '{1, SZ_H, 0, 32'h003, 32'h0000BEEF, 0,
                     0, 1, ERR_MISALIGN, 32'h0, 0};
        vecs[11] = '{0, SZ_B, 1, 32'h100, 0, 32'h0000007F,
                     0, 0, ERR_NONE, 32'h0000007F, 0};
        vecs[12] = '{0, SZ_H, 1, 32'h101, 0, 32'hFFFFFFFF,
                     0, 1, ERR_MISALIGN, 32'h0, 0};
        vecs[13] = '{0, SZ_B, 1, 32'h101, 0, 32'h0000AB00,
                     1, 0, ERR_NONE, 32'hFFFFFFAB, 0};

        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = SZ_B;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.ddt_in     = '0;
        bus.ackd_n     = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mreq", bus.mreq, 1'b0);
        chk("rst_write", bus.write, 1'b0);
        chk("rst_oe", bus.ddt_oe, 1'b0);
        chk("rst_rvalid", bus.resp_valid, 1'b0);
        chk("rst_rerr", bus.resp_err, 1'b0);
        chk("rst_size", bus.size, 2'b00);
        chk("rst_dad", bus.dad, 32'h0);
        chk("rst_ddt_out", bus.ddt_out, 32'h0);
        chk("rst_rdata", bus.resp_rdata, 32'h0);
        chk("rst_code", bus.resp_err_code, 2'b00);
        chk("rst_stall", bus.stall, 1'b0);
        rst = 1'b0;

        // ackd_n low while idle must not start anything.
        bus.ackd_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_ack_mreq", bus.mreq, 1'b0);
        chk("idle_ack_rvalid", bus.resp_valid, 1'b0);
        bus.ackd_n = 1'b1;

        for (int i = 0; i < NV; i++) do_access(i, vecs[i]);

        // Reset in the second BUSY cycle drops the access.
        set_req(vecs[0]);
        @(posedge clk); #1;
        chk("rstb_busy1", bus.mreq, 1'b1);
        @(posedge clk); #1;
        chk("rstb_busy2", bus.mreq, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstb_mreq", bus.mreq, 1'b0);
        chk("rstb_rvalid", bus.resp_valid, 1'b0);
        chk("rstb_dad", bus.dad, 32'h0);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstb_rvalid2", bus.resp_valid, 1'b0);
        chk("rstb_mreq2", bus.mreq, 1'b0);
        do_access(100, vecs[0]);

`ifdef MEM_BUS_TIMEOUT_EN
        begin
            int  nb, cyc;
            bit  got;
            nb = 0; cyc = 0; got = 0;
            set_req(vecs[0]);
            while (!got && cyc < 40) begin
                @(posedge clk); #1;
                cyc++;
                if (bus.mreq) nb++;
                if (bus.resp_valid) begin
                    got = 1;
                    chk("to_err", bus.resp_err, 1'b1);
                    chk("to_code", bus.resp_err_code, ERR_TIMEOUT);
                    chk("to_rdata", bus.resp_rdata, 32'h0);
                    chk("to_mreq", bus.mreq, 1'b0);
                end
            end
            if (!got) begin
                n_cmp++; n_err++;
                $display("FAIL to_wait: no resp_valid in 40 cycles");
            end
            chk("to_nbusy", nb, 4);
            bus.req_valid = 1'b0;
            @(posedge clk); #1;
            chk("to_pulse", bus.resp_valid, 1'b0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
